// File: rtl/axil_ic_pkg.sv
// Shared types and helpers for the priority AXI-Lite interconnect arbiters.
package axil_ic_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;

  localparam int unsigned MAX_MASTERS = 32;
  localparam int unsigned MAX_ID_W    = $clog2(MAX_MASTERS);

  // OR-reduction encoder: only valid for one-hot or all-zero inputs.
  function automatic logic [MAX_ID_W-1:0] onehot_to_bin(input logic [MAX_MASTERS-1:0] oh);
    logic [MAX_ID_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) b = b | MAX_ID_W'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/axil_prio_select.sv
// Combinational rotating-start priority selector: first set request at or
// after i_start (wrapping) wins; returns one-hot and binary winner.
module axil_prio_select
  import axil_ic_pkg::*;
#(
  parameter  int NUMBER_MASTER = 4,
  localparam int ID_WIDTH      = $clog2(NUMBER_MASTER)
) (
  input  logic [NUMBER_MASTER-1:0] i_req,
  input  logic [ID_WIDTH-1:0]      i_start,
  output logic [NUMBER_MASTER-1:0] o_grant,
  output logic [ID_WIDTH-1:0]      o_grant_id
);

  localparam int unsigned N_U = NUMBER_MASTER;

  always_comb begin : search
    logic        found;
    int unsigned idx;
    o_grant = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N_U; i++) begin
      idx = (32'(i_start) + i) % N_U;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
      end
    end
  end

  assign o_grant_id = ID_WIDTH'(onehot_to_bin(MAX_MASTERS'(o_grant)));

endmodule

// File: rtl/axil_arbiter_rd.sv
// AXI-Lite read-channel arbiter: holds one grant from AR acceptance to R handshake.
// Define AXIL_ARB_RD_ROUND_ROBIN_EN for round-robin; fixed lowest-index priority otherwise.
module axil_arbiter_rd
  import axil_ic_pkg::*;
#(
  parameter  int NUMBER_MASTER = 4,
  localparam int ID_WIDTH      = $clog2(NUMBER_MASTER)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] m_axil_arvalid,
  input  logic                     ar_ready,
  input  logic                     r_valid,
  input  logic                     r_ready,
  output logic [NUMBER_MASTER-1:0] grant,
  output logic [ID_WIDTH-1:0]      grant_id,
  output logic                     grant_valid,
  output logic                     ar_phase
);

  arb_state_t               r_state, w_state_nxt;
  logic [NUMBER_MASTER-1:0] r_grant, w_grant_nxt;
  logic [ID_WIDTH-1:0]      r_grant_id, w_grant_id_nxt;
  logic                     r_grant_valid, w_grant_valid_nxt;
  logic                     r_ar_phase, w_ar_phase_nxt;
  logic [NUMBER_MASTER-1:0] w_win;
  logic [ID_WIDTH-1:0]      w_win_id;
  logic [ID_WIDTH-1:0]      w_start;
  logic                     w_ar_hs;

`ifdef AXIL_ARB_RD_ROUND_ROBIN_EN
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUMBER_MASTER - 1);
  logic [ID_WIDTH-1:0] r_rr_ptr, w_rr_ptr_nxt;

  assign w_start = (r_rr_ptr == LAST_ID) ? '0 : r_rr_ptr + ID_WIDTH'(1);
`else
  assign w_start = '0;
`endif

  axil_prio_select #(.NUMBER_MASTER(NUMBER_MASTER)) u_sel (
    .i_req      (m_axil_arvalid),
    .i_start    (w_start),
    .o_grant    (w_win),
    .o_grant_id (w_win_id)
  );

  assign w_ar_hs = m_axil_arvalid[r_grant_id] & ar_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_ar_phase_nxt    = r_ar_phase;
`ifdef AXIL_ARB_RD_ROUND_ROBIN_EN
    w_rr_ptr_nxt      = r_rr_ptr;
`endif
    case (r_state)
      IDLE: if (|m_axil_arvalid) begin
        w_grant_nxt       = w_win;
        w_grant_id_nxt    = w_win_id;
        w_grant_valid_nxt = 1'b1;
        w_ar_phase_nxt    = 1'b1;
        w_state_nxt       = ADDR;
`ifdef AXIL_ARB_RD_ROUND_ROBIN_EN
        w_rr_ptr_nxt      = w_win_id;
`endif
      end
      ADDR: if (w_ar_hs) begin
        w_ar_phase_nxt = 1'b0;
        w_state_nxt    = DATA;
      end
      DATA: if (r_valid && r_ready) begin
        w_grant_nxt       = '0;
        w_grant_id_nxt    = '0;
        w_grant_valid_nxt = 1'b0;
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_ar_phase    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_ar_phase    <= w_ar_phase_nxt;
    end
  end

`ifdef AXIL_ARB_RD_ROUND_ROBIN_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) r_rr_ptr <= LAST_ID;
    else          r_rr_ptr <= w_rr_ptr_nxt;
  end
`endif

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign ar_phase    = r_ar_phase;

endmodule

// File: tb/tb_axil_arbiter_rd.sv
// Scoreboard bench for axil_arbiter_rd; works with or without AXIL_ARB_RD_ROUND_ROBIN_EN.
module tb_axil_arbiter_rd;

  localparam int NM = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [NM-1:0] m_axil_arvalid;
  logic          ar_ready, r_valid, r_ready;
  logic [NM-1:0] grant;
  logic [1:0]    grant_id;
  logic          grant_valid, ar_phase;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] id;
    logic       gv;
    logic       ph;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 aclk = ~aclk;

  axil_arbiter_rd #(.NUMBER_MASTER(NM)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .m_axil_arvalid (m_axil_arvalid),
    .ar_ready       (ar_ready),
    .r_valid        (r_valid),
    .r_ready        (r_ready),
    .grant          (grant),
    .grant_id       (grant_id),
    .grant_valid    (grant_valid),
    .ar_phase       (ar_phase)
  );

  // Monitor: 1 time unit after each edge, compare against the oldest expectation.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (grant !== e.g || grant_id !== e.id || grant_valid !== e.gv || ar_phase !== e.ph) begin
          errors++;
          $display("FAIL %s: got grant=%b id=%0d gv=%b ph=%b, want grant=%b id=%0d gv=%b ph=%b",
                   e.name, grant, grant_id, grant_valid, ar_phase, e.g, e.id, e.gv, e.ph);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input string name, input logic rst_n, input logic [3:0] arv,
                      input logic ard, input logic rv, input logic rr,
                      input logic [3:0] eg, input logic [1:0] eid, input logic eph);
    exp_t e;
    @(posedge aclk);
    #2;
    aresetn        = rst_n;
    m_axil_arvalid = arv;
    ar_ready       = ard;
    r_valid        = rv;
    r_ready        = rr;
    e.name = name; e.g = eg; e.id = eid; e.gv = |eg; e.ph = eph;
    q.push_back(e);
  endtask

  initial begin
    int rr_seq [5];
`ifdef AXIL_ARB_RD_ROUND_ROBIN_EN
    rr_seq = '{0, 1, 2, 3, 0};
`else
    rr_seq = '{0, 0, 0, 0, 0};
`endif
    aresetn = 1'b0; m_axil_arvalid = '0; ar_ready = 1'b0; r_valid = 1'b0; r_ready = 1'b0;

    step("reset0", 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0);
    step("reset1", 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0);

    // 1: basic transaction, lowest of 1010 wins
    step("t1_grant", 1, 4'b1010, 0, 0, 0, 4'b0010, 2'd1, 1);
    step("t1_ar_hs", 1, 4'b1010, 1, 0, 0, 4'b0010, 2'd1, 0);
    step("t1_rv_only", 1, 4'b0000, 0, 1, 0, 4'b0010, 2'd1, 0);
    step("t1_r_hs", 1, 4'b0000, 0, 1, 1, 4'b0000, 2'd0, 0);
    step("t1_idle", 1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0);

    // 2: master 0 requests while master 2 owns the channel
    step("t2_grant2", 1, 4'b0100, 0, 0, 0, 4'b0100, 2'd2, 1);
    step("t2_ar_hs", 1, 4'b0100, 1, 0, 0, 4'b0100, 2'd2, 0);
    step("t2_hold", 1, 4'b0001, 1, 0, 0, 4'b0100, 2'd2, 0);
    step("t2_r_hs", 1, 4'b0001, 0, 1, 1, 4'b0000, 2'd0, 0);
    step("t2_grant0", 1, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1);
    step("t2_ar_hs0", 1, 4'b0001, 1, 0, 0, 4'b0001, 2'd0, 0);
    step("t2_r_hs0", 1, 4'b0001, 0, 1, 1, 4'b0000, 2'd0, 0);

    // 3: everything asserted; period-3 pattern
    for (int k = 0; k < 2; k++) begin
      step("t3_addr", 1, 4'b0001, 1, 1, 1, 4'b0001, 2'd0, 1);
      step("t3_data", 1, 4'b0001, 1, 1, 1, 4'b0001, 2'd0, 0);
      step("t3_idle", 1, 4'b0001, 1, 1, 1, 4'b0000, 2'd0, 0);
    end

    // 4: reset during DATA
    step("t4_grant3", 1, 4'b1000, 0, 0, 0, 4'b1000, 2'd3, 1);
    step("t4_data", 1, 4'b1000, 1, 0, 0, 4'b1000, 2'd3, 0);
    step("t4_rst", 0, 4'b1111, 0, 0, 0, 4'b0000, 2'd0, 0);
    step("t4_rst_hold", 0, 4'b1111, 0, 0, 0, 4'b0000, 2'd0, 0);
    step("t4_post", 1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0);

    // 6: granted arvalid drops in ADDR; grant is never revoked
    step("t6_grant1", 1, 4'b0010, 0, 0, 0, 4'b0010, 2'd1, 1);
    step("t6_drop", 1, 4'b0001, 1, 0, 0, 4'b0010, 2'd1, 1);
    step("t6_hold", 1, 4'b0011, 0, 0, 0, 4'b0010, 2'd1, 1);
    step("t6_ar_hs", 1, 4'b0011, 1, 0, 0, 4'b0010, 2'd1, 0);
    step("t6_r_hs", 1, 4'b0000, 0, 1, 1, 4'b0000, 2'd0, 0);

    // 5: all masters request continuously from a fresh reset
    step("t5_rst", 0, 4'b1111, 0, 0, 0, 4'b0000, 2'd0, 0);
    for (int t = 0; t < 5; t++) begin
      logic [3:0] oh;
      oh = 4'b0001 << rr_seq[t];
      step("t5_addr", 1, 4'b1111, 1, 1, 1, oh, 2'(rr_seq[t]), 1);
      step("t5_data", 1, 4'b1111, 1, 1, 1, oh, 2'(rr_seq[t]), 0);
      step("t5_idle", 1, 4'b1111, 1, 1, 1, 4'b0000, 2'd0, 0);
    end

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge aclk);
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_rd.md
Name: axil_arbiter_rd

Overview:
Read-channel arbiter for the priority AXI-Lite interconnect. It shares the single downstream read path (address decoder, slave mux, error responder) among NUMBER_MASTER upstream masters. It grants exactly one master at a time and holds that grant from AR acceptance through the R handshake. The grant vector drives the AR/R muxes and gates arvalid into the address decoder.

Parameters:
NUMBER_MASTER, 4, number of requesting masters (>=2).
ID_WIDTH, $clog2(NUMBER_MASTER), localparam; width of grant_id.

Ports:
aclk  in  1  clock
aresetn  in  1  reset: synchronous, active-low, sampled on posedge aclk
m_axil_arvalid  in  NUMBER_MASTER  per-master AR valid (request)
ar_ready  in  1  downstream arready, already muxed from the selected slave or error responder
r_valid  in  1  downstream rvalid, already muxed
r_ready  in  1  rready of the granted master, already muxed
grant  out  NUMBER_MASTER  one-hot grant; all-zero when idle
grant_id  out  ID_WIDTH  binary index of the granted master; 0 when idle
grant_valid  out  1  high when grant is non-zero
ar_phase  out  1  high in the ADDR state; qualifies arvalid forwarding to the decoder

Behaviour:
- Reset values: grant=0, grant_id=0, grant_valid=0, ar_phase=0, state=IDLE, rr pointer=NUMBER_MASTER-1.
- States:
  - IDLE:
    - If |m_axil_arvalid, register the winner into grant/grant_id, set grant_valid=1 and ar_phase=1, go to ADDR.
    - Otherwise stay in IDLE.
  - ADDR:
    - Internal signal ar_hs = m_axil_arvalid[grant_id] & ar_ready.
    - On ar_hs: ar_phase<=0, go to DATA.
    - Otherwise hold. The grant does not move even if the granted arvalid drops (protocol violation); the arbiter never revokes a grant.
  - DATA:
    - On r_valid & r_ready: grant<=0, grant_id<=0, grant_valid<=0, go to IDLE.
    - Otherwise hold.
- Latency:
  - Request to grant: 1 cycle (registered).
  - Minimum transaction occupancy: 3 cycles (IDLE, ADDR, DATA).
  - After R completes, one IDLE cycle always occurs before the next grant. There is no back-to-back regrant.
- Fixed priority (default): the lowest index with arvalid set wins.
- Requests from other masters during ADDR or DATA are ignored. Those masters see arready=0 from the mux.
- Outputs change only on clock edges. grant and grant_id are always consistent, and grant is never multi-hot.
- Simultaneous R handshake and new requests in DATA: the arbiter still goes to IDLE. Arbitration happens on the next cycle.
- Reset mid-transaction: all outputs return to reset values on the next edge, regardless of state. Any in-flight beat is abandoned.
- ar_hs while in DATA or IDLE is ignored.

Optional Feature:
- Macro: AXIL_ARB_RD_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration. The search starts at index (rr_ptr+1) mod NUMBER_MASTER and wraps around.
  - rr_ptr <= winner index on every IDLE->ADDR transition.
  - rr_ptr resets to NUMBER_MASTER-1, so master 0 has first priority after reset.
- Undefined: fixed priority as above. No rr_ptr register exists.

Decomposition:
- Package axil_ic_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t.
  - Function onehot_to_bin, shared with the write-side arbiter.
- One sub-module: axil_prio_select.
  - Combinational.
  - Inputs: req[NUMBER_MASTER] and start index. Outputs: one-hot winner and binary index.
  - Fixed priority uses start=0. Round-robin uses start=rr_ptr+1.

Test Plan:
1. After reset, m_axil_arvalid=4'b1010 -> next edge grant=4'b0010, grant_id=1, ar_phase=1; ar_ready pulse -> ar_phase=0; r_valid&r_ready -> grant=0 next edge.
2. Master 2 granted and in DATA; master 0 raises arvalid -> grant stays 4'b0100 until R handshake; master 0 granted 2 cycles after R handshake.
3. arvalid=4'b0001 held, ar_ready high on the first ADDR cycle, r_valid&r_ready on the first DATA cycle -> grant pattern 1,1,0 with period 3 cycles.
4. aresetn=0 during DATA with grant=4'b1000 -> next edge grant=0, grant_valid=0, state IDLE; no grant while aresetn=0 even with arvalid=4'b1111.
5. Round-robin build, arvalid=4'b1111 continuously, each transaction completed promptly -> grant sequence 0,1,2,3,0; fixed build -> grant_id always 0.
6. Granted arvalid drops in ADDR while another master requests -> grant unchanged, ar_phase stays 1 until ar_hs.
